// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// The control unit's stall logic and the bench both use MDU_LATENCY.
package mult_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mdu_state_t;
  typedef enum logic {OP_MULT, OP_DIV} mdu_op_t;

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_LATENCY = MDU_WIDTH + 2;

  function automatic int mdu_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Signed multiply (Booth radix-2) / divide (restoring, on magnitudes) unit.
// Hi/Lo are internal result registers that feed MFHI/MFLO.
import mult_div_pkg::*;

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] MultA,
  input  logic [WIDTH-1:0] MultB,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t       r_state;
  mdu_state_t       w_state_next;
  mdu_op_t          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_divzero;

  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_booth;
  logic [WIDTH:0]   w_mul_p;
  logic [WIDTH-1:0] w_mul_q;
  logic             w_mul_qm1;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_div_rsh;
  logic [WIDTH:0]   w_div_trial;
  logic [WIDTH:0]   w_div_r;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic             w_start_zero;

  assign w_start_zero = Op & (MultB == '0);

  always_comb begin
    // P carries one extra sign bit so that B = -2^(W-1) cannot overflow.
    w_b_ext = {r_b[WIDTH-1], r_b};
    case ({r_q[0], r_qm1})
      2'b01:   w_booth = r_p + w_b_ext;
      2'b10:   w_booth = r_p - w_b_ext;
      default: w_booth = r_p;
    endcase
    w_mul_p   = {w_booth[WIDTH], w_booth[WIDTH:1]};
    w_mul_q   = {w_booth[0], r_q[WIDTH-1:1]};
    w_mul_qm1 = r_q[0];

    w_abs_b     = r_b[WIDTH-1] ? -r_b : r_b;
    w_div_rsh   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    w_div_trial = w_div_rsh - {1'b0, w_abs_b};
    if (!w_div_trial[WIDTH]) begin
      w_div_r = w_div_trial;
      w_div_q = {r_q[WIDTH-2:0], 1'b1};
    end else begin
      w_div_r = w_div_rsh;
      w_div_q = {r_q[WIDTH-2:0], 1'b0};
    end

    w_quot = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -r_q : r_q;
    w_rem  = r_a[WIDTH-1] ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (Start) w_state_next = w_start_zero ? DONE : RUN;
      RUN:  if (r_cnt == CW'(WIDTH - 1)) w_state_next = FIX;
      FIX:  w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_op      <= OP_MULT;
      r_a       <= '0;
      r_b       <= '0;
      r_p       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == RUN) || (w_state_next == FIX);
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_op      <= mdu_op_t'(Op);
            r_a       <= MultA;
            r_b       <= MultB;
            r_p       <= '0;
            r_q       <= (Op && MultA[WIDTH-1]) ? -MultA : MultA;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_divzero <= w_start_zero;
          end
        end
        RUN: begin
          if (r_op == OP_MULT) begin
            r_p   <= w_mul_p;
            r_q   <= w_mul_q;
            r_qm1 <= w_mul_qm1;
          end else begin
            r_p <= w_div_r;
            r_q <= w_div_q;
          end
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_hi   <= (r_op == OP_MULT) ? r_p[WIDTH-1:0] : w_rem;
          r_lo   <= (r_op == OP_MULT) ? r_q : w_quot;
          r_done <= 1'b1;
        end
        DONE: begin
          // Only the divide-by-zero path enters DONE with the flag still set.
          if (r_divzero) begin
            r_hi   <= r_a;
            r_lo   <= '1;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign DivZero = r_divzero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner-case sequences
// and random operations checked against a plain-arithmetic reference model.
import mult_div_pkg::*;

module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Op;
  logic [31:0] MultA;
  logic [31:0] MultB;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .MultA(MultA), .MultB(MultB), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic; SV division truncates toward zero.
  function automatic void model(input bit op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int n;
    bit dz;
    dz = op && (b == 32'd0);
    @(negedge Clk);
    Start = 1'b1; Op = op; MultA = a; MultB = b;
    @(posedge Clk); #1;
    Start = 1'b0; Op = 1'($urandom); MultA = $urandom; MultB = $urandom;
    check({tag, "_busy"}, 64'(Busy), 64'(!dz));
    n = 1;
    while (!Done && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 64'(Done), 64'd1);
    check({tag, "_latency"}, 64'(n), dz ? 64'd2 : 64'(MDU_LATENCY));
    check({tag, "_hi"}, 64'(Hi), 64'(ehi));
    check({tag, "_lo"}, 64'(Lo), 64'(elo));
    check({tag, "_divzero"}, 64'(DivZero), 64'(dz));
    @(posedge Clk); #1;
    check({tag, "_done_width"}, 64'(Done), 64'd0);
    check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
    $display("[TB] %s op=%0d a=%h b=%h hi=%h lo=%h lat=%0d", tag, op, a, b, Hi, Lo, n);
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] ehi, elo;
    logic [31:0] hold_hi, hold_lo;
    int n, dcount, d1, d2, errs;
    bit busy_at[80];
    bit op;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{1'b1, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 32'd2,          32'd3,         32'd0,         32'd6};

    Reset = 1'b1; Start = 1'b0; Op = 1'b0; MultA = '0; MultB = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_hi", 64'(Hi), 64'd0);
    check("reset_lo", 64'(Lo), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_divzero", 64'(DivZero), 64'd0);
    @(negedge Clk); Reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Start pulsed mid-run with different operands must be ignored.
    @(negedge Clk);
    Start = 1'b1; Op = 1'b0; MultA = 32'd7; MultB = 32'hFFFF_FFFD;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 1;
    while (!Done && n < 100) begin
      if (n == 10) begin
        @(negedge Clk);
        Start = 1'b1; Op = 1'b1; MultA = 32'd123; MultB = 32'd0;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      n++;
    end
    check("midstart_latency", 64'(n), 64'(MDU_LATENCY));
    check("midstart_hi", 64'(Hi), 64'hFFFF_FFFF);
    check("midstart_lo", 64'(Lo), 64'hFFFF_FFEB);
    check("midstart_divzero", 64'(DivZero), 64'd0);
    $display("[TB] midstart hi=%h lo=%h lat=%0d", Hi, Lo, n);
    @(posedge Clk); #1;

    // Reset in the middle of a run aborts with no Done.
    @(negedge Clk);
    Start = 1'b1; Op = 1'b0; MultA = 32'h1234; MultB = 32'h5678;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (n = 1; n < 20; n++) begin
      @(posedge Clk); #1;
    end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("abort_hi", 64'(Hi), 64'd0);
    check("abort_lo", 64'(Lo), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    dcount = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    $display("[TB] abort hi=%h lo=%h done_pulses=%0d", Hi, Lo, dcount);

    // Start held high: two back-to-back operations with one idle cycle between.
    hold_hi = Hi; hold_lo = Lo;
    @(negedge Clk);
    Start = 1'b1; Op = 1'b0; MultA = 32'd5; MultB = 32'd6;
    dcount = 0; d1 = 0; d2 = 0; errs = 0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge Clk); #1;
      busy_at[k] = Busy;
      if (Done) begin
        dcount++;
        if (dcount == 1) d1 = k;
        else if (dcount == 2) d2 = k;
      end
      if (k < MDU_LATENCY && (Hi !== hold_hi || Lo !== hold_lo)) errs++;
      if (k >= MDU_LATENCY && (Hi !== 32'd0 || Lo !== 32'd30)) errs++;
    end
    Start = 1'b0;
    check("held_done_count", 64'(dcount), 64'd2);
    check("held_done1", 64'(d1), 64'(MDU_LATENCY));
    check("held_done2", 64'(d2), 64'(2 * MDU_LATENCY + 1));
    check("held_idle_gap", 64'(busy_at[MDU_LATENCY + 1]), 64'd0);
    check("held_restart", 64'(busy_at[MDU_LATENCY + 2]), 64'd1);
    check("held_hilo_stable", 64'(errs), 64'd0);
    $display("[TB] held done_at=%0d,%0d pulses=%0d hi=%h lo=%h", d1, d2, dcount, Hi, Lo);
    repeat (3) @(posedge Clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(0, 15)) - 32'd8;
        2:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      model(op, a, b, ehi, elo);
      run_op(op, a, b, ehi, elo, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
